// File: rtl/paper_video_timing.sv
// Raster timing generator for the HDMI output path: pulls RGB pixels from the
// pixel FIFO and emits data/DE/HSync/VSync, starting and stopping on frame boundaries.
module paper_video_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_WIDTH = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [23:0] px_data_i,
  input  logic        px_valid_i,
  output logic        px_ready_o,
  output logic [23:0] data_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  input  logic        underflow_clr_i,
  output logic        running_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t H_ACT_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT_END  = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t state, state_next;
  cnt_t   h_cnt, v_cnt;
  logic   running, h_last, frame_last;
  logic   active, hs, vs, underflow_evt;

  always_comb begin
    running       = (state != IDLE);
    h_last        = (h_cnt == H_LAST);
    frame_last    = h_last && (v_cnt == V_LAST);
    // Counters sit at 0 in IDLE, so every decode is qualified by running.
    active        = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs            = running && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs            = running && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    underflow_evt = active && !px_valid_i;
  end

  // No pixel is popped from the FIFO while reset is asserted.
  assign px_ready_o = active && !rst_i;
  assign running_o  = running;

  always_comb begin
    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_next = state;
    case (state)
      IDLE:     if (enable_i) state_next = RUN;
      RUN:      if (!enable_i) state_next = STOPPING;
      STOPPING: begin
        if (enable_i)        state_next = RUN;
        else if (frame_last) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values and simulation order between blocks cannot matter.
    if (rst_i) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      if (!running) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_last) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
      end else begin
        h_cnt <= h_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_o          <= 1'b0;
      data_o        <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      de_o          <= active;
      data_o        <= (active && px_valid_i) ? px_data_i : '0;
      hsync_o       <= hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= vs ? VSYNC_POL : ~VSYNC_POL;
      frame_start_o <= active && (h_cnt == '0) && (v_cnt == '0);
      // A fresh underflow outranks a clear arriving in the same cycle.
      if (underflow_evt)        underflow_o <= 1'b1;
      else if (underflow_clr_i) underflow_o <= 1'b0;
    end
  end

endmodule
